feistel_decrypt_iter: RTL

- Iterative DES decryption engine: the inverse direction of the 16-round unrolled Feistel encryption network.
- Runs one Feistel round per clock, reusing a single round datapath, and applies the subkey schedule in reverse order (K16..K1).
- Sits on the receive side of the cipher path. It takes ciphertext blocks through a valid/ready handshake and returns plaintext through a valid/ready handshake.
- Parameter DECRYPT=0 turns it into an iterative encryptor, which the bench uses to cross-check against the unrolled network.

---
 rtl/feistel_decrypt_iter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/feistel_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : feistel_decrypt_iter
//  Description : Iterative DES Feistel engine. One round per clock through a
//                single shared round datapath. With DECRYPT=1 the subkeys are
//                applied K16 first down to K1, which gives decryption. With
//                DECRYPT=0 they run K1 up to K16, which gives encryption.
//                Blocks enter and leave through valid/ready handshakes.
//  Ports       : clk, rst (async, active-high)
//                in_valid / in_ready / cphrtxt     : input block handshake
//                key_schdl[768]                    : packed subkeys K1..K16,
//                                                    K(i+1) at [48*i +: 48]
//                out_valid / out_ready / plntxt    : result handshake
//                busy                              : engine in RUN or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module feistel_decrypt_iter #(
    parameter bit DECRYPT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  cphrtxt,
    input  logic [767:0] key_schdl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  plntxt,
    output logic         busy
);

    // Permutation tables hold FIPS 46-3 bit numbers (1 = MSB).
    localparam int c_ip [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int c_fp [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int c_e [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int c_p [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // S-box ROMs, each indexed by {row[1:0], col[3:0]}.
    localparam int c_sbox [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Bit permutations. Output bit n (MSB-first) takes input bit table[n].
    // ------------------------------------------------------------------------
    function automatic logic [63:0] f_ip(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63 - i] = d[64 - c_ip[i]];
        return o;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63 - i] = d[64 - c_fp[i]];
        return o;
    endfunction

    function automatic logic [47:0] f_e(input logic [31:0] d);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47 - i] = d[32 - c_e[i]];
        return o;
    endfunction

    function automatic logic [31:0] f_p(input logic [31:0] d);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[31 - i] = d[32 - c_p[i]];
        return o;
    endfunction

    // Round function: expand, mix subkey, substitute, permute.
    function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        int          v;
        x = f_e(r) ^ k;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            b = x[47 - 6*j -: 6];
            // Row comes from the outer bits, column from the inner four.
            v = c_sbox[j][{b[5], b[0], b[4:1]}];
            s[31 - 4*j -: 4] = v[3:0];
        end
        return f_p(s);
    endfunction

    // ------------------------------------------------------------------------
    // Subkey selection
    // ------------------------------------------------------------------------
    logic [47:0] w_sub [16];
    logic [3:0]  w_kidx;
    logic [47:0] w_ksel;

    for (genvar gi = 0; gi < 16; gi++) begin : g_subkey
        assign w_sub[gi] = key_schdl[48*gi +: 48];
    end

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [3:0]  rnd_q, rnd_d;

    // w_sub[n] is K(n+1): decrypt walks K16..K1, encrypt walks K1..K16.
    assign w_kidx = DECRYPT ? (4'd15 - rnd_q) : rnd_q;
    assign w_ksel = w_sub[w_kidx];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            l_q     <= 32'h0;
            r_q     <= 32'h0;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            rnd_q   <= rnd_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, round datapath and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        r_d       = r_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        plntxt    = 64'h0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    {l_d, r_d} = f_ip(cphrtxt);
                    rnd_d      = 4'd0;
                    state_d    = S_RUN;
                end
            end

            S_RUN: begin
                busy  = 1'b1;
                l_d   = r_q;
                r_d   = l_q ^ f_round(r_q, w_ksel);
                // rnd wraps 15 -> 0 on the final round.
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Swapped halves undo the last round's exchange.
                plntxt    = f_fp({r_q, l_q});
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
